// File: rtl/edge_pkg.sv
// Shared types for the edge-detector window controller: FSM state encoding and position width.
package edge_pkg;

  localparam int POS_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WRITE = 3'd2,
    ST_WIN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/edge_pos_counter.sv
// Column/row position tracker for the frame walk, with last-word and window-eligible flags.
module edge_pos_counter
  import edge_pkg::*;
#(
  parameter int WIDTH_WORDS = 160,
  parameter int HEIGHT      = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [POS_W-1:0] col,
  output logic [POS_W-1:0] row,
  output logic             last_word,
  output logic             win_eligible
);

  logic [POS_W-1:0] col_r;
  logic [POS_W-1:0] row_r;

  // Position registers: column wraps at end of line and bumps the row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_r <= {POS_W{1'b0}};
      row_r <= {POS_W{1'b0}};
    end else if (clear) begin
      col_r <= {POS_W{1'b0}};
      row_r <= {POS_W{1'b0}};
    end else if (advance) begin
      if (col_r == POS_W'(WIDTH_WORDS - 1)) begin
        col_r <= {POS_W{1'b0}};
        row_r <= row_r + POS_W'(1);
      end else begin
        col_r <= col_r + POS_W'(1);
      end
    end else begin
      col_r <= col_r;
      row_r <= row_r;
    end
  end

  assign col          = col_r;
  assign row          = row_r;
  assign last_word    = (col_r == POS_W'(WIDTH_WORDS - 1)) && (row_r == POS_W'(HEIGHT - 1));
  // Column 0 pairs with the previous line's last word, so it never forms a window.
  assign win_eligible = (row_r >= POS_W'(2)) && (col_r >= POS_W'(1));

endmodule

// File: rtl/edge_window_controller.sv
// Fetches a frame into the line-buffer datapath and flags valid 3-row windows for the Sobel stage.
// Optional STALL_COUNT_EN adds a saturating stall_cycles counter output.
module edge_window_controller
  import edge_pkg::*;
#(
  parameter int WIDTH_WORDS = 160,
  parameter int HEIGHT      = 480,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dp_write_en,
  output logic [DATA_W-1:0] dp_data_in,
  output logic              win_valid,
  output logic [15:0]       win_x,
  output logic [15:0]       win_y,
  input  logic              win_ready
`ifdef STALL_COUNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  state_t            state_r;
  logic              busy_r;
  logic              done_r;
  logic              mem_req_r;
  logic [ADDR_W-1:0] addr_ptr_r;
  logic              dp_write_en_r;
  logic [DATA_W-1:0] dp_data_r;
  logic              win_valid_r;
  logic [15:0]       win_x_r;
  logic [15:0]       win_y_r;

  logic [POS_W-1:0]  col_s;
  logic [POS_W-1:0]  row_s;
  logic              last_word_s;
  logic              win_eligible_s;
  logic              clear_s;
  logic              advance_s;

  assign clear_s   = (state_r == ST_IDLE) && start;
  assign advance_s = ((state_r == ST_WRITE) && !win_eligible_s && !last_word_s) ||
                     ((state_r == ST_WIN) && win_ready && !last_word_s);

  edge_pos_counter #(
    .WIDTH_WORDS (WIDTH_WORDS),
    .HEIGHT      (HEIGHT)
  ) u_pos (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear_s),
    .advance      (advance_s),
    .col          (col_s),
    .row          (row_s),
    .last_word    (last_word_s),
    .win_eligible (win_eligible_s)
  );

  // Frame sequencer; the address is a running word pointer that tracks the position counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      mem_req_r     <= 1'b0;
      addr_ptr_r    <= {ADDR_W{1'b0}};
      dp_write_en_r <= 1'b0;
      dp_data_r     <= {DATA_W{1'b0}};
      win_valid_r   <= 1'b0;
      win_x_r       <= 16'd0;
      win_y_r       <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            addr_ptr_r <= base_addr;
            busy_r     <= 1'b1;
            mem_req_r  <= 1'b1;
            state_r    <= ST_REQ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            dp_data_r     <= mem_rdata;
            dp_write_en_r <= 1'b1;
            mem_req_r     <= 1'b0;
            state_r       <= ST_WRITE;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WRITE: begin
          dp_write_en_r <= 1'b0;
          if (win_eligible_s) begin
            win_valid_r <= 1'b1;
            win_x_r     <= col_s - POS_W'(1);
            win_y_r     <= row_s - POS_W'(2);
            state_r     <= ST_WIN;
          end else if (last_word_s) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            addr_ptr_r <= addr_ptr_r + ADDR_W'(1);
            mem_req_r  <= 1'b1;
            state_r    <= ST_REQ;
          end
        end
        ST_WIN: begin
          if (win_ready) begin
            win_valid_r <= 1'b0;
            if (last_word_s) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_DONE;
            end else begin
              addr_ptr_r <= addr_ptr_r + ADDR_W'(1);
              mem_req_r  <= 1'b1;
              state_r    <= ST_REQ;
            end
          end else begin
            state_r <= ST_WIN;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r       <= ST_IDLE;
          busy_r        <= 1'b0;
          done_r        <= 1'b0;
          mem_req_r     <= 1'b0;
          dp_write_en_r <= 1'b0;
          win_valid_r   <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign mem_req     = mem_req_r;
  assign mem_addr    = addr_ptr_r;
  assign dp_write_en = dp_write_en_r;
  assign dp_data_in  = dp_data_r;
  assign win_valid   = win_valid_r;
  assign win_x       = win_x_r;
  assign win_y       = win_y_r;

`ifdef STALL_COUNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles lost to memory wait or Sobel back-pressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'd0;
    end else if (clear_s) begin
      stall_cnt_r <= 16'd0;
    end else if ((((state_r == ST_REQ) && !mem_ack) || ((state_r == ST_WIN) && !win_ready)) &&
                 (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_edge_window_controller.sv
// Directed self-checking bench for edge_window_controller on a 4x3-word frame at base 0x100.
module tb_edge_window_controller;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam logic [AW-1:0] NO_ADDR = 18'h3FFFF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          busy;
  logic          done;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          dp_write_en;
  logic [DW-1:0] dp_data_in;
  logic          win_valid;
  logic [15:0]   win_x;
  logic [15:0]   win_y;
  logic          win_ready;
`ifdef STALL_COUNT_EN
  logic [15:0]   stall_cycles;
`endif

  edge_window_controller #(.WIDTH_WORDS(W), .HEIGHT(H), .ADDR_W(AW), .DATA_W(DW)) dut (
`ifdef STALL_COUNT_EN
    .stall_cycles (stall_cycles),
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .busy        (busy),
    .done        (done),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .dp_write_en (dp_write_en),
    .dp_data_in  (dp_data_in),
    .win_valid   (win_valid),
    .win_x       (win_x),
    .win_y       (win_y),
    .win_ready   (win_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observations gathered by run_frame
  logic [DW-1:0] wr_q[$];
  logic [31:0]   win_q[$];
  int            done_cnt, overlap_cnt, req_in_win_cnt, addr_unstable_cnt;
  int            hold_cnt, win_hold_cnt, last_accept_cyc, done_cyc;
  logic [AW-1:0] first_fetch;
  logic          timed_out, aborted;

  // Drives one frame: memory returns data=address, optional ack delay, window stall,
  // extra start pulse, or reset when a given address is requested.
  task automatic run_frame(input logic [AW-1:0] base, input logic [AW-1:0] wait_addr,
                           input int wait_n, input int stall_n, input int start_at,
                           input logic [AW-1:0] abort_addr);
    int cyc, waited, stalled, accepted;
    logic prev_req, prev_ack, want_fetch;
    logic [AW-1:0] prev_addr;
    wr_q.delete(); win_q.delete();
    done_cnt = 0; overlap_cnt = 0; req_in_win_cnt = 0; addr_unstable_cnt = 0;
    hold_cnt = 0; win_hold_cnt = 0; last_accept_cyc = -10; done_cyc = -1;
    first_fetch = NO_ADDR; timed_out = 1'b0; aborted = 1'b0;
    cyc = 0; waited = 0; stalled = 0; accepted = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; want_fetch = 1'b0;
    @(negedge clk);
    base_addr = base; start = 1'b1; mem_ack = 1'b0; win_ready = 1'b0;
    while (cyc < 300 && done_cnt == 0 && !aborted) begin
      @(negedge clk);
      cyc++;
      start = (wr_q.size() == start_at) ? 1'b1 : 1'b0;
      if (mem_req && prev_req && !prev_ack && mem_addr !== prev_addr) addr_unstable_cnt++;
      if (dp_write_en) begin
        wr_q.push_back(dp_data_in);
        if (mem_req) overlap_cnt++;
      end
      if (win_valid && mem_req) req_in_win_cnt++;
      if (win_valid && accepted == 0) win_hold_cnt++;
      if (want_fetch && mem_req) begin
        first_fetch = mem_addr;
        want_fetch = 1'b0;
      end
      if (mem_req && mem_addr == wait_addr) hold_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mem_req && mem_addr == abort_addr) begin
        rst_n = 1'b0; mem_ack = 1'b0; win_ready = 1'b0; aborted = 1'b1;
      end else begin
        mem_rdata = DW'(mem_addr);
        if (mem_req && mem_addr == wait_addr && waited < wait_n) begin
          mem_ack = 1'b0;
          waited++;
        end else begin
          mem_ack = mem_req;
        end
        if (win_valid && accepted == 0 && stalled < stall_n) begin
          win_ready = 1'b0;
          stalled++;
        end else if (win_valid) begin
          win_ready = 1'b1;
          win_q.push_back({win_x, win_y});
          accepted++;
          last_accept_cyc = cyc;
          if (accepted == 1) want_fetch = 1'b1;
        end else begin
          win_ready = 1'b0;
        end
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
    end
    timed_out = (done_cnt == 0) && !aborted;
    start = 1'b0; mem_ack = 1'b0; win_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; base_addr = 18'h00100;
    mem_ack = 1'b0; mem_rdata = 32'd0; win_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, mem_req, mem_addr, dp_write_en, dp_data_in, win_valid, win_x, win_y} !== 117'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b req=%b addr=%h we=%b data=%h wv=%b x=%0d y=%0d, want all 0",
               busy, done, mem_req, mem_addr, dp_write_en, dp_data_in, win_valid, win_x, win_y);
    end
    rst_n = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b mem_req=%b, want 0/0", busy, mem_req);
    end
  endtask

  task automatic check_stream(input string name);
    int errs;
    errs = 0;
    for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== 32'h100 + 32'(i)) errs++;
    total++;
    if (wr_q.size() != 12 || errs != 0) begin
      bad++;
      $display("FAIL %s_stream: got %0d writes with %0d wrong data, want 12 writes 0x100..0x10B", name, wr_q.size(), errs);
    end
  endtask

  task automatic test_full_frame();
    run_frame(18'h00100, NO_ADDR, 0, 0, -1, NO_ADDR);
    total++;
    if (timed_out) begin
      bad++;
      $display("FAIL full_timeout: got no done, want done within budget");
    end
    check_stream("full");
    total++;
    if (win_q.size() != 3 || win_q[0] !== 32'h0000_0000 || win_q[1] !== 32'h0001_0000 || win_q[2] !== 32'h0002_0000) begin
      bad++;
      $display("FAIL full_windows: got %0d windows, want (0,0)(1,0)(2,0)", win_q.size());
    end
    total++;
    if (done_cyc !== last_accept_cyc + 1) begin
      bad++;
      $display("FAIL full_done_timing: got done at %0d, want %0d", done_cyc, last_accept_cyc + 1);
    end
    total++;
    if (overlap_cnt != 0) begin
      bad++;
      $display("FAIL full_req_write_overlap: got %0d, want 0", overlap_cnt);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL full_after_done: got busy=%b done=%b, want 0/0", busy, done);
    end
  endtask

  task automatic test_mem_wait();
    run_frame(18'h00100, 18'h00105, 3, 0, -1, NO_ADDR);
    check_stream("wait");
    total++;
    if (hold_cnt != 4 || addr_unstable_cnt != 0) begin
      bad++;
      $display("FAIL wait_addr_hold: got %0d cycles unstable=%0d, want 4 cycles unstable=0", hold_cnt, addr_unstable_cnt);
    end
    total++;
    if (overlap_cnt != 0 || done_cnt != 1) begin
      bad++;
      $display("FAIL wait_write_during_req: got overlap=%0d done=%0d, want 0/1", overlap_cnt, done_cnt);
    end
`ifdef STALL_COUNT_EN
    total++;
    if (stall_cycles !== 16'd3) begin
      bad++;
      $display("FAIL wait_stall_count: got %0d, want 3", stall_cycles);
    end
`endif
  endtask

  task automatic test_backpressure();
    run_frame(18'h00100, NO_ADDR, 0, 5, -1, NO_ADDR);
    total++;
    if (win_hold_cnt != 6 || win_q.size() == 0 || win_q[0] !== 32'h0000_0000) begin
      bad++;
      $display("FAIL bp_window_hold: got %0d valid cycles, want 6 with (0,0)", win_hold_cnt);
    end
    total++;
    if (req_in_win_cnt != 0) begin
      bad++;
      $display("FAIL bp_no_fetch: got %0d req cycles during window, want 0", req_in_win_cnt);
    end
    total++;
    if (first_fetch !== 18'h0010A) begin
      bad++;
      $display("FAIL bp_next_fetch: got %h, want 0010a", first_fetch);
    end
    check_stream("bp");
`ifdef STALL_COUNT_EN
    repeat (3) @(negedge clk);
    total++;
    if (stall_cycles !== 16'd5) begin
      bad++;
      $display("FAIL bp_stall_count: got %0d, want 5 held after done", stall_cycles);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    int late_done;
    run_frame(18'h00100, NO_ADDR, 0, 0, -1, 18'h00106);
    total++;
    if (!aborted) begin
      bad++;
      $display("FAIL mid_reset_reach: got no request to 0x106, want one");
    end
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got req=%b busy=%b done=%b, want 0/0/0", mem_req, busy, done);
    end
    rst_n = 1'b1;
    late_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    total++;
    if (late_done != 0) begin
      bad++;
      $display("FAIL mid_reset_no_done: got %0d done/busy cycles, want 0", late_done);
    end
    run_frame(18'h00100, NO_ADDR, 0, 0, -1, NO_ADDR);
    check_stream("restart");
    total++;
    if (done_cnt != 1 || win_q.size() != 3) begin
      bad++;
      $display("FAIL restart_frame: got done=%0d windows=%0d, want 1/3", done_cnt, win_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    run_frame(18'h00100, NO_ADDR, 0, 0, 3, NO_ADDR);
    check_stream("busy_start");
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL busy_start_done: got %0d, want 1", done_cnt);
    end
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL busy_start_restart: got busy=%b req=%b, want 0/0", busy, mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_mem_wait();
    test_backpressure();
    test_reset_mid_frame();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_window_controller.md
Name: edge_window_controller

Overview:
- Sequences the edge detector's line-buffer datapath (shift_data_path). Fetches a frame word by word from pixel memory and drives `write_en`/`data_in` into the datapath.
- Tracks column and row position, flags when the 3-row window on w0..w5 is valid for the Sobel stage, and stalls fetching while that stage back-pressures.
- Sits between the memory interface and shift_data_path; owned by the top-level edge detector.

Parameters:
- WIDTH_WORDS, 160, words per image line (4 pixels per 32-bit word).
- HEIGHT, 480, lines per frame.
- ADDR_W, 18, memory word-address width.
- DATA_W, 32, datapath word width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin frame; sampled only in IDLE
- base_addr  in  ADDR_W  frame start word address, latched on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, frame complete
- mem_req  out  1  read request, held until mem_ack
- mem_addr  out  ADDR_W  read word address
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  DATA_W  read data
- dp_write_en  out  1  to shift_data_path write_en
- dp_data_in  out  DATA_W  to shift_data_path data_in
- win_valid  out  1  w0..w5 hold a complete window
- win_x  out  16  window column index (word)
- win_y  out  16  window row index (centre row - 1)
- win_ready  in  1  Sobel stage accepts window

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset `rst_n` is synchronous and active-low.
  - On reset: all outputs 0; FSM to IDLE; counters cleared.
  - Reset mid-frame abandons the frame: mem_req drops the next edge and no done pulse is issued.
- FSM states: IDLE, REQ, WRITE, WIN, DONE.
  - IDLE: on start=1, latch base_addr, col=row=0, busy=1, go to REQ. start is ignored in all other states.
  - REQ: mem_req=1, mem_addr=base+row*WIDTH_WORDS+col (running pointer, no multiplier). mem_addr and mem_req stay stable until mem_ack. A same-cycle ack is legal. On ack: register mem_rdata into dp_data_in and go to WRITE.
  - WRITE: dp_write_en=1 for exactly one cycle.
    - If row>=2 and col>=1, go to WIN.
    - Else if this is the last word, go to DONE.
    - Else advance position and go to REQ.
  - WIN: win_valid=1, win_x=col-1, win_y=row-2, all held stable until win_ready.
    - On win_ready=1, win_valid drops the next cycle.
    - Then go to DONE if this is the last word, otherwise advance position and go to REQ.
    - No fetch is issued while in WIN.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Position advance and geometry:
  - col wraps WIDTH_WORDS-1 -> 0 with row+1.
  - Last word is col=WIDTH_WORDS-1 and row=HEIGHT-1.
  - No window at col 0 of any row: the line-boundary word pair is invalid.
  - Windows per frame: (HEIGHT-2)*(WIDTH_WORDS-1).
- Cycle cost and ordering:
  - Minimum 2 cycles per word (REQ with immediate ack, then WRITE).
  - A window adds at least 1 cycle.
  - dp_write_en never asserts in the same cycle as mem_req.
- Address arithmetic wraps modulo 2^ADDR_W, with no error flag.
- mem_ack outside REQ is ignored.

Optional Feature:
- Macro STALL_COUNT_EN.
- Defined: adds output stall_cycles[15:0].
  - Cleared on accepted start.
  - Increments each cycle in REQ with mem_ack=0, or in WIN with win_ready=0.
  - Saturates at 16'hFFFF.
  - Holds its value after done.
- Undefined: port absent, no counter logic.

Decomposition:
- Package edge_pkg: FSM state enum (IDLE/REQ/WRITE/WIN/DONE), POS_W=16 position width constant.
- One natural sub-module, edge_pos_counter: col/row counters with wrap, the last-word flag and the window-eligible flag.
- FSM, address pointer and output registers stay in the top module.

Test Plan (WIDTH_WORDS=4, HEIGHT=3, base=0x100, memory returns data=address):
- Reset/idle: rst_n=0 for 2 cycles with start=1 -> all outputs 0; after release with start=0, stays IDLE, busy=0.
- Full frame, ack same cycle, win_ready=1:
  - 12 dp_write_en pulses carrying 0x100..0x10B in order.
  - win_valid 3 times with (win_x,win_y) = (0,0), (1,0), (2,0).
  - done one cycle after the last window; total words=12.
- Memory wait: ack delayed 3 cycles on word 5 -> mem_addr=0x105 held stable 4 cycles, no dp_write_en during the wait, stream otherwise unchanged.
- Window back-pressure: win_ready=0 for 5 cycles on first window -> win_valid and win_x=0 held, mem_req stays 0, next fetch address is 0x10A. With STALL_COUNT_EN, stall_cycles=5.
- Reset mid-frame: rst_n=0 while in REQ on word 6 -> next cycle mem_req=0, busy=0, no done. A new start then refetches from base_addr.
- Start while busy: start pulsed at word 3 -> ignored; exactly one done for the frame.
